// File: rtl/spi_byte_master.sv
// spi_byte_master: byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One request shifts din out on pin_mosi and captures one byte from pin_miso into dout.
// Chip-select is handled outside this block.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer; SCLK low; waiting for wr
// LOW   | SCLK low phase; MOSI bit is set up, MISO sampled at phase end
// HIGH  | SCLK high phase; shift to next bit or finish at phase end
module spi_byte_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       busy,
    output logic [7:0] dout,
    output logic       pin_sclk,
    output logic       pin_mosi,
    input  logic       pin_miso
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    // Only the bits still to be sent after the one on pin_mosi are kept.
    logic [6:0]       tx_sr, tx_sr_nxt;
    logic [7:0]       rx_sr, rx_sr_nxt;
    logic             busy_nxt;
    logic [7:0]       dout_nxt;
    logic             sclk_nxt;
    logic             mosi_nxt;
    logic             phase_end;

    assign phase_end = (div_cnt == DIV_LAST);

    // State and all datapath/output registers; reset discards any partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            busy     <= 1'b0;
            dout     <= 8'h00;
            pin_sclk <= 1'b0;
            pin_mosi <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx_sr    <= tx_sr_nxt;
            rx_sr    <= rx_sr_nxt;
            busy     <= busy_nxt;
            dout     <= dout_nxt;
            pin_sclk <= sclk_nxt;
            pin_mosi <= mosi_nxt;
        end
    end

    // Next-state: each SCLK phase lasts CLK_DIV cycles; the 8th high phase returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (wr) state_nxt = LOW;
            LOW:  if (phase_end) state_nxt = HIGH;
            HIGH: begin
                if (phase_end) begin
                    state_nxt = (bit_cnt == 3'd7) ? IDLE : LOW;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and shift/counter registers.
    always_comb begin
        div_cnt_nxt = div_cnt;
        bit_cnt_nxt = bit_cnt;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        busy_nxt    = busy;
        dout_nxt    = dout;
        sclk_nxt    = pin_sclk;
        mosi_nxt    = pin_mosi;
        case (state)
            IDLE: begin
                if (wr) begin
                    busy_nxt    = 1'b1;
                    tx_sr_nxt   = din[6:0];
                    mosi_nxt    = din[7];
                    bit_cnt_nxt = 3'd0;
                    div_cnt_nxt = '0;
                end
            end
            LOW: begin
                if (phase_end) begin
                    div_cnt_nxt = '0;
                    sclk_nxt    = 1'b1;
                    rx_sr_nxt   = {rx_sr[6:0], pin_miso};
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    div_cnt_nxt = '0;
                    sclk_nxt    = 1'b0;
                    if (bit_cnt != 3'd7) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        mosi_nxt    = tx_sr[6];
                        tx_sr_nxt   = {tx_sr[5:0], 1'b0};
                    end else begin
                        // pin_mosi keeps bit 0 until the next request.
                        dout_nxt = rx_sr;
                        busy_nxt = 1'b0;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            default: begin
                div_cnt_nxt = '0;
            end
        endcase
    end

endmodule
